// File: rtl/stream_pattern_source_if.sv
// stream_pattern_source_if: valid/ready/last/data stream bundle with master (source) and slave (sink) modports
interface stream_pattern_source_if #(parameter int DATA_WIDTH = 32);
  logic valid, ready, last;
  logic [DATA_WIDTH-1:0] data;
  modport master(output valid, data, last, input ready);
  modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/stream_pattern_source.sv
// stream_pattern_source: i_en-throttled packet pattern source (ports i_clk, i_s_rst_n, i_en, i_start, src master, o_busy, o_done, o_pkt_cnt); STREAM_PATTERN_SOURCE_LFSR_EN selects an LFSR pattern
module stream_pattern_source #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN = 16,
  parameter int PKT_NUM = 4,
  parameter logic [63:0] START_VALUE = 64'd0
) (
  input logic i_clk,
  input logic i_s_rst_n,
  input logic i_en,
  input logic i_start,
  stream_pattern_source_if.master src,
  output logic o_busy,
  output logic o_done,
  output logic [15:0] o_pkt_cnt
);
  localparam int bw = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam logic [DATA_WIDTH-1:0] start_raw = DATA_WIDTH'(START_VALUE);
  if (PKT_LEN < 1 || DATA_WIDTH < 8 || DATA_WIDTH > 64) begin : g_bad_params
    $error("stream_pattern_source: PKT_LEN must be >= 1 and DATA_WIDTH within 8..64");
  end
`ifdef STREAM_PATTERN_SOURCE_LFSR_EN
  function automatic logic [63:0] m(input int a, input int b, input int c, input int d);
    m = (64'd1 << (a - 1)) | (b > 0 ? 64'd1 << (b - 1) : 64'd0) |
        (c > 0 ? 64'd1 << (c - 1) : 64'd0) | (d > 0 ? 64'd1 << (d - 1) : 64'd0);
  endfunction
  function automatic logic [63:0] taps(input int w);
    case (w)
      8: taps = m(8, 6, 5, 4);       9: taps = m(9, 5, 0, 0);
      10: taps = m(10, 7, 0, 0);     11: taps = m(11, 9, 0, 0);
      12: taps = m(12, 6, 4, 1);     13: taps = m(13, 4, 3, 1);
      14: taps = m(14, 5, 3, 1);     15: taps = m(15, 14, 0, 0);
      16: taps = m(16, 15, 13, 4);   17: taps = m(17, 14, 0, 0);
      18: taps = m(18, 11, 0, 0);    19: taps = m(19, 6, 2, 1);
      20: taps = m(20, 17, 0, 0);    21: taps = m(21, 19, 0, 0);
      22: taps = m(22, 21, 0, 0);    23: taps = m(23, 18, 0, 0);
      24: taps = m(24, 23, 22, 17);  25: taps = m(25, 22, 0, 0);
      26: taps = m(26, 6, 2, 1);     27: taps = m(27, 5, 2, 1);
      28: taps = m(28, 25, 0, 0);    29: taps = m(29, 27, 0, 0);
      30: taps = m(30, 6, 4, 1);     31: taps = m(31, 28, 0, 0);
      32: taps = m(32, 22, 2, 1);    33: taps = m(33, 20, 0, 0);
      34: taps = m(34, 27, 2, 1);    35: taps = m(35, 33, 0, 0);
      36: taps = m(36, 25, 0, 0);    37: taps = m(37, 5, 4, 3) | m(2, 1, 0, 0);
      38: taps = m(38, 6, 5, 1);     39: taps = m(39, 35, 0, 0);
      40: taps = m(40, 38, 21, 19);  41: taps = m(41, 38, 0, 0);
      42: taps = m(42, 41, 20, 19);  43: taps = m(43, 42, 38, 37);
      44: taps = m(44, 43, 18, 17);  45: taps = m(45, 44, 42, 41);
      46: taps = m(46, 45, 26, 25);  47: taps = m(47, 42, 0, 0);
      48: taps = m(48, 47, 21, 20);  49: taps = m(49, 40, 0, 0);
      50: taps = m(50, 49, 24, 23);  51: taps = m(51, 50, 36, 35);
      52: taps = m(52, 49, 0, 0);    53: taps = m(53, 52, 38, 37);
      54: taps = m(54, 53, 18, 17);  55: taps = m(55, 31, 0, 0);
      56: taps = m(56, 55, 35, 34);  57: taps = m(57, 50, 0, 0);
      58: taps = m(58, 39, 0, 0);    59: taps = m(59, 58, 38, 37);
      60: taps = m(60, 59, 0, 0);    61: taps = m(61, 60, 46, 45);
      62: taps = m(62, 61, 6, 5);    63: taps = m(63, 62, 0, 0);
      64: taps = m(64, 63, 61, 60);
      default: taps = 64'd0;
    endcase
  endfunction
  localparam logic [DATA_WIDTH-1:0] taps_mask = DATA_WIDTH'(taps(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] start_word = start_raw == '0 ? DATA_WIDTH'(1) : start_raw;
  function automatic logic [DATA_WIDTH-1:0] step(input logic [DATA_WIDTH-1:0] w);
    step = (w >> 1) ^ (w[0] ? taps_mask : '0);
  endfunction
`else
  localparam logic [DATA_WIDTH-1:0] start_word = start_raw;
  function automatic logic [DATA_WIDTH-1:0] step(input logic [DATA_WIDTH-1:0] w);
    step = w + 1'b1;
  endfunction
`endif
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state;
  logic [bw-1:0] idx, idx_n;
  logic [15:0] cnt_n;
  logic [DATA_WIDTH-1:0] word_n;
  logic xfer, fin;
  always_comb begin
    xfer = src.valid & src.ready;
    idx_n = xfer ? (src.last ? '0 : idx + 1'b1) : idx;
    cnt_n = o_pkt_cnt + 16'(xfer & src.last);
    word_n = xfer ? step(src.data) : src.data;
    fin = xfer & src.last & (PKT_NUM != 0) & (cnt_n == 16'(PKT_NUM));
  end
  always_ff @(posedge i_clk) begin
    if (!i_s_rst_n) begin
      state <= IDLE;
      idx <= '0;
      src.valid <= 1'b0;
      src.last <= 1'b0;
      src.data <= start_word;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_pkt_cnt <= '0;
    end else if (state != SEND) begin
      src.valid <= 1'b0;
      if (i_start) begin
        state <= SEND;
        idx <= '0;
        src.last <= 1'b0;
        src.data <= start_word;
        o_busy <= 1'b1;
        o_done <= 1'b0;
        o_pkt_cnt <= '0;
      end
    end else begin
      idx <= idx_n;
      o_pkt_cnt <= cnt_n;
      if (fin) begin
        state <= DONE;
        src.valid <= 1'b0;
        src.last <= 1'b0;
        src.data <= word_n;
        o_busy <= 1'b0;
        o_done <= 1'b1;
      end else if (!src.valid || xfer) begin
        // offer register is free: take a new beat only when the throttle allows it
        src.valid <= i_en;
        src.data <= word_n;
        src.last <= idx_n == bw'(PKT_LEN - 1);
      end
    end
  end
endmodule

// File: tb/tb_stream_pattern_source.sv
// tb_stream_pattern_source: randomized scoreboard bench for two stream_pattern_source configurations
module tb_stream_pattern_source;
  localparam int la = 4;
  localparam int na = 2;
  localparam logic [31:0] sa = 32'hFFFF_FFFE;
  localparam logic [7:0] sb = 8'hF0;
  typedef struct {
    logic [31:0] d;
    logic l;
    logic [15:0] c;
    logic f;
  } item_t;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, start = 1'b0, ready = 1'b0;
  logic [1:0] vld, lst, bsy, dn;
  logic [31:0] dat[2];
  logic [15:0] cnt[2];
  item_t q[2][$];
  int errors = 0, checks = 0;
  int a_state = 0;
  logic b_run = 1'b0;
  logic hold[2] = '{1'b0, 1'b0};
  logic quiet[2] = '{1'b0, 1'b0};
  logic pend_c[2] = '{1'b0, 1'b0};
  logic pend_f[2] = '{1'b0, 1'b0};
  logic hl[2];
  logic [31:0] hd[2];
  logic [15:0] pc[2];
  stream_pattern_source_if #(.DATA_WIDTH(32)) ifa ();
  stream_pattern_source_if #(.DATA_WIDTH(8)) ifb ();
  assign ifa.ready = ready;
  assign ifb.ready = ready;
  assign vld = {ifb.valid, ifa.valid};
  assign lst = {ifb.last, ifa.last};
  assign dat[0] = ifa.data;
  assign dat[1] = {24'd0, ifb.data};
  stream_pattern_source #(.DATA_WIDTH(32), .PKT_LEN(la), .PKT_NUM(na), .START_VALUE(64'(sa))) dut_a (
    .i_clk(clk), .i_s_rst_n(rst_n), .i_en(en), .i_start(start), .src(ifa.master),
    .o_busy(bsy[0]), .o_done(dn[0]), .o_pkt_cnt(cnt[0]));
  stream_pattern_source #(.DATA_WIDTH(8), .PKT_LEN(1), .PKT_NUM(0), .START_VALUE(64'(sb))) dut_b (
    .i_clk(clk), .i_s_rst_n(rst_n), .i_en(en), .i_start(start), .src(ifb.master),
    .o_busy(bsy[1]), .o_done(dn[1]), .o_pkt_cnt(cnt[1]));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", n, i, act, exp, $time);
    end
  endtask
  task automatic push_run(input int i);
    item_t it;
    q[i].delete();
    for (int k = 0; k < (i == 0 ? la * na : 4000); k++) begin
      it.d = i == 0 ? sa + 32'(k) : {24'd0, sb + 8'(k)};
      it.l = i == 0 ? (k % la) == la - 1 : 1'b1;
      it.c = i == 0 ? 16'(k / la + 1) : 16'(k + 1);
      it.f = i == 0 && k == la * na - 1;
      q[i].push_back(it);
    end
  endtask
  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start;
    start = 1'b1;
    if (a_state != 1) begin
      push_run(0);
      a_state = 1;
    end
    if (!b_run) begin
      push_run(1);
      b_run = 1'b1;
    end
    step_clk();
    start = 1'b0;
  endtask
  task automatic wait_a_data(input logic [31:0] v);
    for (int n = 0; n < 100; n++) begin
      step_clk();
      if (vld[0] && dat[0] == v) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_a_data timeout want=%0h", v);
  endtask
  task automatic wait_a_done;
    for (int n = 0; n < 400; n++) begin
      if (a_state == 2) return;
      step_clk();
    end
    checks++;
    errors++;
    $display("FAIL wait_a_done timeout");
  endtask
  task automatic check_reset;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", i, 64'(vld[i]), 0);
      chk("rst_last", i, 64'(lst[i]), 0);
      chk("rst_busy", i, 64'(bsy[i]), 0);
      chk("rst_done", i, 64'(dn[i]), 0);
      chk("rst_cnt", i, 64'(cnt[i]), 0);
    end
    chk("rst_data", 0, 64'(dat[0]), 64'(sa));
    chk("rst_data", 1, 64'(dat[1]), 64'(sb));
  endtask
  always @(negedge clk) begin
    item_t it;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        hold[i] = 1'b0;
        quiet[i] = 1'b0;
        pend_c[i] = 1'b0;
        pend_f[i] = 1'b0;
      end else begin
        if (pend_c[i]) chk("pkt_cnt", i, 64'(cnt[i]), 64'(pc[i]));
        if (pend_f[i]) begin
          chk("done", i, 64'(dn[i]), 1);
          chk("busy_after_run", i, 64'(bsy[i]), 0);
          chk("valid_after_run", i, 64'(vld[i]), 0);
        end
        if (hold[i]) begin
          chk("hold_valid", i, 64'(vld[i]), 1);
          chk("hold_data", i, 64'(dat[i]), 64'(hd[i]));
          chk("hold_last", i, 64'(lst[i]), 64'(hl[i]));
        end
        if (quiet[i]) chk("valid_while_en_low", i, 64'(vld[i]), 0);
        pend_c[i] = 1'b0;
        pend_f[i] = 1'b0;
        if (vld[i] && ready) begin
          if (q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat[%0d] got=%0h", i, dat[i]);
          end else begin
            it = q[i].pop_front();
            chk("data", i, 64'(dat[i]), 64'(it.d));
            chk("last", i, 64'(lst[i]), 64'(it.l));
            pend_c[i] = it.l;
            pc[i] = it.c;
            pend_f[i] = it.f;
            if (i == 0 && it.f) a_state = 2;
          end
        end
        hold[i] = vld[i] && !ready;
        hd[i] = dat[i];
        hl[i] = lst[i];
        quiet[i] = (!vld[i] || ready) && !en;
      end
    end
  end
  initial begin
    int run;
    repeat (3) step_clk();
    check_reset();
    rst_n = 1'b1;
    en = 1'b1;
    ready = 1'b1;
    step_clk();
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      chk("start_busy", i, 64'(bsy[i]), 1);
      chk("start_valid", i, 64'(vld[i]), 0);
    end
    step_clk();
    for (int i = 0; i < 2; i++) chk("first_valid", i, 64'(vld[i]), 1);
    wait_a_done();
    step_clk();
    chk("a_done_cnt", 0, 64'(cnt[0]), 64'(na));
    chk("a_done_flag", 0, 64'(dn[0]), 1);
    pulse_start();
    chk("restart_done_clear", 0, 64'(dn[0]), 0);
    chk("restart_busy", 0, 64'(bsy[0]), 1);
    wait_a_data(sa + 32'd5);
    ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      en = 1'($urandom);
      step_clk();
    end
    en = 1'b1;
    pulse_start();
    en = 1'b0;
    step_clk();
    en = 1'b1;
    step_clk();
    ready = 1'b1;
    wait_a_done();
    run = 0;
    for (int n = 0; n < 1000; n++) begin
      if (run == 0) begin
        en = !en;
        run = en ? $urandom_range(40, 30) : $urandom_range(20, 10);
      end
      run--;
      ready = n < 500 ? 1'b1 : ($urandom_range(3, 0) != 0);
      if (a_state == 2 && $urandom_range(7, 0) == 0) pulse_start();
      else step_clk();
    end
    en = 1'b1;
    ready = 1'b1;
    wait_a_done();
    pulse_start();
    wait_a_data(sa + 32'd2);
    rst_n = 1'b0;
    q[0].delete();
    q[1].delete();
    a_state = 0;
    b_run = 1'b0;
    step_clk();
    check_reset();
    rst_n = 1'b1;
    step_clk();
    pulse_start();
    chk("post_reset_cnt", 0, 64'(cnt[0]), 0);
    wait_a_done();
    repeat (3) step_clk();
    chk("a_queue_drained", 0, 64'(q[0].size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_pattern_source.md
Name: stream_pattern_source

Overview:
- Synthesizable stream source that feeds the sync FIFO write side in the FIFO test environment.
- Emits a deterministic data pattern in packets over a valid/ready handshake.
- Insertion of beats is throttled by the 1-bit random state signal from the upstream random state generator (i_en), giving bursty, irregular write traffic.
- A downstream checker can predict every data word and last flag from the parameters alone.

Parameters:
DATA_WIDTH, 32, width of o_data (legal range 8..64).
PKT_LEN, 16, beats per packet (>= 1); o_last marks the final beat.
PKT_NUM, 4, packets per run; 0 = run forever.
START_VALUE, 0, first data word after reset or i_start.

Ports:
i_clk  in  1  clock, all logic on posedge.
i_s_rst_n  in  1  reset, synchronous, active-low.
i_en  in  1  throttle from the random state generator; 1 = a new beat may be offered.
i_start  in  1  single-cycle pulse; starts a run from IDLE or DONE.
i_ready  in  1  sink (FIFO not full) accepts the current beat.
o_valid  out  1  beat offered.
o_data  out  DATA_WIDTH  beat payload.
o_last  out  1  final beat of a packet.
o_busy  out  1  state is SEND.
o_done  out  1  run complete; held high until the next i_start or reset.
o_pkt_cnt  out  16  number of packets fully accepted in the current run.

Behaviour:
- All outputs are registered. Reset values: o_valid=0, o_last=0, o_busy=0, o_done=0, o_pkt_cnt=0, o_data=START_VALUE. Internal beat counter = 0. State = IDLE.
- Reset has priority over every other input. Reset asserted mid-packet drops o_valid on the next edge with no handshake completion. There is no resume: the next run restarts from START_VALUE.
- Handshake: a transfer occurs on an edge where o_valid=1 and i_ready=1.
  - Once o_valid=1, o_valid, o_data and o_last stay stable until the transfer, regardless of i_en.
  - o_valid never depends combinationally on i_ready.
- State machine: IDLE, SEND, DONE.
  - IDLE: i_start=1 -> SEND; the data word is loaded with START_VALUE and the counters are cleared.
  - SEND: the offer register is "free" when o_valid=0 or a transfer occurs this cycle. When free: o_valid <= i_en; o_data <= next word; o_last <= (next beat index == PKT_LEN-1).
    - next word = current word + 1 if a transfer occurs, else current word. Arithmetic is modulo 2^DATA_WIDTH; all-ones wraps to 0.
    - Beat index increments on each transfer. It wraps to 0 after the transfer carrying o_last=1; o_pkt_cnt increments on that same edge.
    - When that wrap brings o_pkt_cnt to PKT_NUM (PKT_NUM != 0): go to DONE, o_valid <= 0.
  - DONE: o_done=1, o_valid=0. i_start=1 -> SEND with a fresh run (data = START_VALUE, counters = 0, o_done <= 0).
- i_start while in SEND is ignored.
- Latency: i_start sampled at edge N; o_busy=1 after N. The first o_valid=1 appears after edge N+1 if i_en=1 at N+1. i_en low simply delays that edge by edge.
- PKT_LEN=1: every beat has o_last=1.
- PKT_NUM=0: the block never enters DONE. o_pkt_cnt wraps 0xFFFF -> 0.
- i_en=1 while o_valid=1 and i_ready=0 has no effect (hold).
- Parameter check: PKT_LEN < 1 or DATA_WIDTH outside 8..64 -> $error at elaboration.

Optional Feature:
Macro: STREAM_PATTERN_SOURCE_LFSR_EN
- Defined: the next word is a Galois LFSR step of the current word instead of +1.
  - Taps: DATA_WIDTH=32 uses 0x80200003; other widths use the maximal-length polynomial from a fixed internal table.
  - START_VALUE=0 is replaced by 1 to avoid the lock-up state.
  - All handshake, last and counting behaviour is unchanged.
- Undefined: incrementing pattern as above. No LFSR logic is present in the netlist.

Test Plan:
1. i_en=1, i_ready=1 constant, PKT_LEN=4, PKT_NUM=2, START_VALUE=0, pulse i_start
   -> 8 back-to-back transfers with data 0..7; o_last on data 3 and 7; o_pkt_cnt reaches 2; o_done=1 on the edge after data 7.
2. i_ready held 0 for 5 cycles while o_valid=1 with data 5, and i_en toggling
   -> o_valid/o_data/o_last stay constant (5) for all 5 cycles; data 6 is offered only after the transfer.
3. i_en driven by the random state generator (10..20 low / 30..40 high), i_ready=1, PKT_NUM=0, 1000 cycles
   -> accepted data is strictly consecutive with no gaps; o_valid never rises while i_en=0 and the offer register is free.
4. START_VALUE=0xFFFFFFFE, PKT_LEN=4
   -> accepted sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; o_last on 00000001.
5. Reset asserted mid-packet at beat 2 of PKT_LEN=4, then a new i_start
   -> o_valid=0 on the next edge; new run starts at START_VALUE with o_pkt_cnt=0; the first o_last comes after 4 new beats.
6. i_start pulsed during SEND, and again in DONE
   -> ignored in SEND (data continues without restart); from DONE, o_done clears and data restarts at START_VALUE.
